// File: rtl/counter_pkg.sv
// Shared constants for the multimode ring/Johnson counter.
package counter_pkg;

   // Pattern family selected by the mode input.
   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;

   // Seed codes, zero-extended to the counter width by users.
   localparam int unsigned SEED_RING    = 1;
   localparam int unsigned SEED_JOHNSON = 0;

endpackage : counter_pkg

// File: rtl/shift_code_check.sv
// Combinational legality check and step-index decode for ring / Johnson codes.
module shift_code_check
   import counter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]             code,
   input  logic                     mode,
   output logic                     legal,
   output logic [$clog2(2*N)-1:0]   index
);

   localparam int PW = $clog2(2 * N);
   localparam logic [N-1:0] One = 1;

   logic [N-1:0] inv;
   int unsigned  pop;
   int unsigned  idx_ring;
   int unsigned  idx_john;
   logic         legal_ring;
   logic         legal_john;

   assign inv = ~code;

   // Popcount, hot-bit position and contiguous-run tests for both code families.
   always_comb begin
      pop      = 0;
      idx_ring = 0;
      for (int i = 0; i < N; i++) begin
         if (code[i]) begin
            pop      = pop + 1;
            idx_ring = i;
         end
      end
      legal_ring = (pop == 1);
      // Johnson codes are a run of ones anchored at bit 0, or a run anchored at the MSB.
      if (code[0]) begin
         legal_john = ((code & (code + One)) == '0);
      end else begin
         legal_john = ((inv & (inv + One)) == '0);
      end
      if (code[0] || (code == '0)) begin
         idx_john = pop;
      end else begin
         idx_john = 2 * N - pop;
      end
   end

   // Select per mode; index is meaningless when the code is illegal.
   always_comb begin
      if (mode == MODE_JOHNSON) begin
         legal = legal_john;
         index = PW'(idx_john);
      end else begin
         legal = legal_ring;
         index = PW'(idx_ring);
      end
   end

endmodule : shift_code_check

// File: rtl/multimode_ring_counter.sv
// Ring / Johnson counter with direction, load, self-correction and wrap/illegal flags.
module multimode_ring_counter
   import counter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     mode,
   input  logic                     dir,
   input  logic                     load,
   input  logic [N-1:0]             load_val,
   output logic [N-1:0]             count,
   output logic [$clog2(2*N)-1:0]   pos,
   output logic                     wrap,
   output logic                     illegal
);

   localparam int PW = $clog2(2 * N);

   logic [N-1:0]  count_q, count_d;
   logic [PW-1:0] pos_q, pos_d;
   logic          mode_q, mode_d;
   logic          wrap_q, wrap_d;
   logic          illegal_q, illegal_d;

   logic          load_legal, cnt_legal;
   logic [PW-1:0] load_idx, cnt_idx;
   logic [N-1:0]  seed_in, seed_cur, step_count;
   logic [PW-1:0] last_pos, step_pos;

   shift_code_check #(.N(N)) u_chk_load (
      .code  (load_val),
      .mode  (mode_q),
      .legal (load_legal),
      .index (load_idx)
   );

   shift_code_check #(.N(N)) u_chk_cnt (
      .code  (count_q),
      .mode  (mode_q),
      .legal (cnt_legal),
      .index (cnt_idx)
   );

   assign seed_in  = (mode == MODE_JOHNSON) ? N'(SEED_JOHNSON) : N'(SEED_RING);
   assign seed_cur = (mode_q == MODE_JOHNSON) ? N'(SEED_JOHNSON) : N'(SEED_RING);
   assign last_pos = (mode_q == MODE_JOHNSON) ? PW'(2 * N - 1) : PW'(N - 1);

   // Candidate pattern and index for a single en step in the current mode and direction.
   always_comb begin
      step_count = count_q;
      step_pos   = cnt_idx;
      if (mode_q == MODE_JOHNSON) begin
         step_count = dir ? {~count_q[0], count_q[N-1:1]} : {count_q[N-2:0], ~count_q[N-1]};
      end else begin
         step_count = dir ? {count_q[0], count_q[N-1:1]} : {count_q[N-2:0], count_q[N-1]};
      end
      if (dir) begin
         step_pos = (cnt_idx == '0) ? last_pos : cnt_idx - PW'(1);
      end else begin
         step_pos = (cnt_idx == last_pos) ? '0 : cnt_idx + PW'(1);
      end
   end

   // Next-state priority: mode change > load > corruption fix > step > hold.
   always_comb begin
      count_d   = count_q;
      pos_d     = pos_q;
      mode_d    = mode_q;
      wrap_d    = 1'b0;
      illegal_d = 1'b0;
      if (mode != mode_q) begin
         count_d = seed_in;
         pos_d   = '0;
         mode_d  = mode;
      end else if (load) begin
         if (load_legal) begin
            count_d = load_val;
            pos_d   = load_idx;
         end else begin
            count_d   = seed_cur;
            pos_d     = '0;
            illegal_d = 1'b1;
         end
      end else if (!cnt_legal) begin
         count_d   = seed_cur;
         pos_d     = '0;
         illegal_d = 1'b1;
      end else if (en) begin
         count_d = step_count;
         pos_d   = step_pos;
         wrap_d  = (step_count == seed_cur);
      end
   end

   // State register with synchronous reset taking the mode input's seed.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= seed_in;
         pos_q     <= '0;
         mode_q    <= mode;
         wrap_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         pos_q     <= pos_d;
         mode_q    <= mode_d;
         wrap_q    <= wrap_d;
         illegal_q <= illegal_d;
      end
   end

   assign count   = count_q;
   assign pos     = pos_q;
   assign wrap    = wrap_q;
   assign illegal = illegal_q;

endmodule : multimode_ring_counter

// File: tb/tb_multimode_ring_counter.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares each cycle.
module tb_multimode_ring_counter;

   localparam int N  = 4;
   localparam int PW = $clog2(2 * N);

   typedef struct packed {
      logic [N-1:0]  c;
      logic [PW-1:0] p;
      logic          w;
      logic          i;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          mode = 1'b0;
   logic          dir = 1'b0;
   logic          load = 1'b0;
   logic [N-1:0]  load_val = '0;
   logic [N-1:0]  count;
   logic [PW-1:0] pos;
   logic          wrap;
   logic          illegal;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t want;
   exp_t got;

   // Reference state: mode, step index and the raw code (raw so corruption can be modelled).
   bit           m_mode = 1'b0;
   int           m_pos = 0;
   logic [N-1:0] m_code = '0;

   multimode_ring_counter #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .pos      (pos),
      .wrap     (wrap),
      .illegal  (illegal)
   );

   always #5 clk = ~clk;

   function automatic int len_of(bit md);
      return md ? 2 * N : N;
   endfunction

   // Code at step k: ring = single bit k; Johnson = k low ones, or (2N-k) high ones past N.
   function automatic logic [N-1:0] code_of(bit md, int k);
      logic [N-1:0] c;
      c = '0;
      if (!md) begin
         c[k] = 1'b1;
      end else if (k <= N) begin
         for (int i = 0; i < k; i++) c[i] = 1'b1;
      end else begin
         for (int i = N - (2 * N - k); i < N; i++) c[i] = 1'b1;
      end
      return c;
   endfunction

   function automatic bit find_idx(bit md, logic [N-1:0] c, output int idx);
      idx = 0;
      for (int k = 0; k < len_of(md); k++) begin
         if (code_of(md, k) == c) begin
            idx = k;
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   task automatic model_step(input bit r, input bit e, input bit md, input bit d, input bit l,
                             input logic [N-1:0] lv);
      exp_t x;
      int   idx;
      bit   ew, ei;
      ew = 1'b0;
      ei = 1'b0;
      if (r || (md != m_mode)) begin
         m_mode = md;
         m_pos  = 0;
         m_code = code_of(md, 0);
      end else if (l) begin
         if (find_idx(m_mode, lv, idx)) begin
            m_code = lv;
            m_pos  = idx;
         end else begin
            m_code = code_of(m_mode, 0);
            m_pos  = 0;
            ei     = 1'b1;
         end
      end else if (!find_idx(m_mode, m_code, idx)) begin
         m_code = code_of(m_mode, 0);
         m_pos  = 0;
         ei     = 1'b1;
      end else if (e) begin
         m_pos  = d ? (m_pos + len_of(m_mode) - 1) % len_of(m_mode)
                    : (m_pos + 1) % len_of(m_mode);
         m_code = code_of(m_mode, m_pos);
         ew     = (m_pos == 0);
      end
      x.c = m_code;
      x.p = PW'(m_pos);
      x.w = ew;
      x.i = ei;
      exp_q.push_back(x);
   endtask

   task automatic apply(input bit r, input bit e, input bit md, input bit d, input bit l,
                        input logic [N-1:0] lv);
      @(negedge clk);
      rst      = r;
      en       = e;
      mode     = md;
      dir      = d;
      load     = l;
      load_val = lv;
      model_step(r, e, md, d, l, lv);
   endtask

   // Overwrite the count register with a given code for one cycle, then let the DUT react.
   task automatic corrupt(input logic [N-1:0] c);
      @(negedge clk);
      rst  = 1'b0;
      en   = 1'b1;
      mode = m_mode;
      dir  = 1'b0;
      load = 1'b0;
      force dut.count_q = c;
      #1 release dut.count_q;
      m_code = c;
      model_step(1'b0, 1'b1, m_mode, 1'b0, 1'b0, '0);
   endtask

   // Monitor: outputs are valid every cycle once a prediction is pending.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got  = '{c: count, p: pos, w: wrap, i: illegal};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL cycle_out t=%0t: got count=%b pos=%0d wrap=%b illegal=%b, need count=%b pos=%0d wrap=%b illegal=%b",
                     $time, got.c, got.p, got.w, got.i, want.c, want.p, want.w, want.i);
         end
      end
   end

   initial begin
      logic [N-1:0] lv;
      bit           md;

      // Ring, left, full revolution.
      apply(1, 0, 0, 0, 0, '0);
      repeat (4) apply(0, 1, 0, 0, 0, '0);

      // Johnson: mode change, 8 left steps, one right step.
      apply(0, 0, 1, 0, 0, '0);
      repeat (8) apply(0, 1, 1, 0, 0, '0);
      apply(0, 1, 1, 1, 0, '0);

      // Ring loads: legal 0100 then illegal 0110.
      apply(0, 0, 0, 0, 0, '0);
      apply(0, 0, 0, 0, 1, 4'b0100);
      apply(0, 0, 0, 0, 1, 4'b0110);

      // Mode toggle mid-sequence with en high takes no step.
      repeat (2) apply(0, 1, 0, 0, 0, '0);
      apply(0, 1, 1, 0, 0, '0);
      apply(0, 1, 1, 1, 0, '0);

      // Reset beats load, en and mode change together.
      apply(1, 1, 0, 1, 1, 4'b0100);

      // Corrupted ring count, then corrupted Johnson count.
      apply(0, 1, 0, 0, 0, '0);
      corrupt(4'b0011);
      apply(0, 1, 0, 1, 0, '0);

      // en low with dir toggling: hold.
      for (int i = 0; i < 4; i++) apply(0, 0, 0, i[0], 0, '0);

      apply(0, 0, 1, 0, 0, '0);
      repeat (3) apply(0, 1, 1, 0, 0, '0);
      corrupt(4'b0101);
      apply(0, 1, 1, 1, 0, '0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         md = m_mode ^ ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 1) == 0) lv = code_of(m_mode, $urandom_range(0, len_of(m_mode) - 1));
         else lv = N'($urandom);
         apply($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, md,
               $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, lv);
      end

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d predictions left, need 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_multimode_ring_counter

// File: doc/multimode_ring_counter.md
MULTIMODE_RING_COUNTER -- requirements
Module: multimode_ring_counter

Interface
REQ-001 SHALL have parameter N, default 4: counter width in bits; legal range is N >= 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port en, input, 1 bit: advance the pattern by one step when high.
REQ-005 SHALL have port mode, input, 1 bit: 0 = ring (one-hot), 1 = Johnson (twisted ring).
REQ-006 SHALL have port dir, input, 1 bit: 0 = shift left (bit i to bit i+1), 1 = shift right.
REQ-007 SHALL have port load, input, 1 bit: load request, qualifies load_val.
REQ-008 SHALL have port load_val, input, N bits: pattern to load.
REQ-009 SHALL have port count, output, N bits: current pattern, registered.
REQ-010 SHALL have port pos, output, $clog2(2N) bits: step index of count, registered.
REQ-011 SHALL have port wrap, output, 1 bit: one-cycle flag, registered.
REQ-012 SHALL have port illegal, output, 1 bit: one-cycle flag, registered.

Function
REQ-013 SHALL define L as N in ring mode and 2N in Johnson mode; seed SHALL be 1 (bit 0 set) in ring mode and 0 in Johnson mode.
REQ-014 SHALL, on a ring left step, set count to {count[N-2:0], count[N-1]}; on a ring right step, to {count[0], count[N-1:1]}.
REQ-015 SHALL, on a Johnson left step, set count to {count[N-2:0], ~count[N-1]}; on a Johnson right step, to {~count[0], count[N-1:1]}.
REQ-016 SHALL, on each step, increment pos modulo L when dir=0 and decrement pos modulo L when dir=1.
REQ-017 SHALL keep pos equal to the code index at all times: ring = index of the hot bit; Johnson = popcount(count) if count[0]=1 or count=0, else 2N - popcount(count).
REQ-018 SHALL treat as legal only the L valid codes of the current mode: ring = exactly one bit set; Johnson = one of the 2N twisted-ring codes.
REQ-019 SHALL register the mode as mode_q; when mode != mode_q, count SHALL reload the seed of the new mode, pos SHALL become 0, and mode_q SHALL update, in one cycle.
REQ-020 SHALL, when load=1 and load_val is legal for mode_q, set count to load_val and pos to its index on the next edge.
REQ-021 SHALL, when load=1 and load_val is illegal, set count to the seed and pos to 0, and pulse illegal=1 for one cycle.
REQ-022 SHALL, when the registered count is illegal (corruption), set count to the seed and pos to 0 on the next edge, and pulse illegal=1.
REQ-023 SHALL apply priority per edge as: rst > mode change > load > illegal-state correction > en step > hold.
REQ-024 SHALL assert wrap=1 for exactly the cycles in which count equals the seed as a result of an en step, in either direction.
REQ-025 SHALL keep wrap low after a reset, load, mode change or correction, even when the result equals the seed.
REQ-026 SHALL hold count and pos and drive wrap=0 and illegal=0 when en=0 and no higher-priority event is active.
REQ-027 SHALL ignore dir in every cycle that is not a step.

Reset
REQ-028 SHALL, when rst=1 at an edge, set count = seed(mode input), pos = 0, mode_q = mode, wrap = 0 and illegal = 0.
REQ-029 SHALL override any load, en or mode change in the same cycle with rst, including mid-sequence.

Structure
REQ-030 SHALL take the mode encodings MODE_RING = 0 and MODE_JOHNSON = 1 and the seed constants from the shared package counter_pkg.
REQ-031 SHALL instantiate one combinational sub-module, shift_code_check (parameter N; inputs code and mode; outputs legal and index), used for both load_val and the registered count.
REQ-032 SHALL keep every output driven directly from a flop, with no combinational path from input to output.

Verification
REQ-033 SHALL test ring mode, N=4, rst then en=1 and dir=0 for 4 cycles -> count 0001,0010,0100,1000,0001; pos 0,1,2,3,0; wrap high only on the final 0001.
REQ-034 SHALL test Johnson mode, N=4, dir=0 for 8 steps -> codes 0001,0011,0111,1111,1110,1100,1000,0000 with pos 1..7,0 and wrap on 0000; then dir=1 for one step -> 1000 with pos=7.
REQ-035 SHALL test ring mode with load=1 and load_val=0100 -> count=0100, pos=2; then load_val=0110 -> count=0001, pos=0, illegal pulse, wrap=0.
REQ-036 SHALL test a mode toggle 0->1 mid-sequence with en=1 -> count=0000, pos=0, no step taken that cycle, wrap=0.
REQ-037 SHALL test rst with load, en and mode change all asserted together -> reset values only; and a forced illegal count 0011 in ring mode -> next cycle count=0001 with illegal pulse.
REQ-038 SHALL test en=0 with dir toggling -> count and pos unchanged, wrap and illegal low.
